// File: rtl/jt12_mmr_pkg.sv
// Shared definitions for the JT12 host-write front end: register map,
// dispatcher state encoding and the queued write entry layout.
package jt12_mmr_pkg;

  localparam logic [7:0] REG_TESTYM  = 8'h21;
  localparam logic [7:0] REG_LFO     = 8'h22;
  localparam logic [7:0] REG_CLKA1   = 8'h24;
  localparam logic [7:0] REG_CLKA2   = 8'h25;
  localparam logic [7:0] REG_CLKB    = 8'h26;
  localparam logic [7:0] REG_TIMER   = 8'h27;
  localparam logic [7:0] REG_KON     = 8'h28;
  localparam logic [7:0] REG_PCM     = 8'h2A;
  localparam logic [7:0] REG_PCM_EN  = 8'h2B;
  localparam logic [7:0] REG_DACTEST = 8'h2C;
  localparam logic [7:0] REG_CLK_N6  = 8'h2D;
  localparam logic [7:0] REG_CLK_N3  = 8'h2E;
  localparam logic [7:0] REG_CLK_N2  = 8'h2F;

  // First channel/operator register; everything below is global.
  localparam logic [7:0] REG_CHOP_BASE = 8'h30;

  // Widest bank field carried through the queue (up to 8 banks).
  localparam int unsigned BANK_W_MAX = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } mmr_state_t;

  typedef struct packed {
    logic [BANK_W_MAX-1:0] bank;
    logic [7:0]            regn;
    logic [7:0]            data;
  } wentry_t;

  // Channel/operator slot 3 does not exist in any bank; such writes are dropped.
  function automatic logic is_discard(input logic [7:0] regn);
    return (regn >= REG_CHOP_BASE) && (regn[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/jt12_mmr_wfifo.sv
// Synchronous write FIFO with full/empty flags. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module jt12_mmr_wfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = r_mem[r_rd_ptr[PW-1:0]];

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= din;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/jt12_mmr_q.sv
// JT12 host-write front end: edge-detected host writes, queued data writes,
// clk_en-paced dispatch with a busy hold, global register decode and a
// channel/operator update strobe for the register file.
module jt12_mmr_q
  import jt12_mmr_pkg::*;
#(
  parameter int unsigned BANKS = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cen,
  output logic                        clk_en,
  input  logic                        write,
  input  logic [$clog2(BANKS):0]      addr,
  input  logic [7:0]                  din,
  output logic                        busy,
  output logic                        ovf,
  output logic                        lfo_en,
  output logic [2:0]                  lfo_freq,
  output logic [9:0]                  value_A,
  output logic [7:0]                  value_B,
  output logic                        load_A,
  output logic                        load_B,
  output logic                        clr_flag_A,
  output logic                        clr_flag_B,
  output logic                        enable_irq_A,
  output logic                        enable_irq_B,
  output logic                        csm,
  output logic                        effect,
  output logic                        fast_timers,
  output logic                        pg_stop,
  output logic                        eg_stop,
  output logic [8:0]                  pcm,
  output logic                        pcm_en,
  output logic                        up_valid,
  output logic [7:0]                  up_reg,
  output logic [7:0]                  up_din,
  output logic [1+$clog2(BANKS):0]    up_ch,
  output logic [1:0]                  up_op
);

  localparam int unsigned CW        = 2 + $clog2(BANKS);
  localparam int unsigned EW        = $bits(wentry_t);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD - 1);

  // Host interface
  logic                  r_write;
  logic                  w_wr_edge;
  logic [7:0]            r_sel_reg;
  logic [BANK_W_MAX-1:0] r_sel_bank;

  // Queue
  wentry_t               w_push_entry;
  wentry_t               w_head;
  logic [EW-1:0]         w_fifo_dout;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;

  // Divider
  logic [2:0]            r_cen_cnt;
  logic [2:0]            r_cen_lim;
  logic [2:0]            r_cen_lim_nxt;

  // Dispatcher
  mmr_state_t            r_state;
  mmr_state_t            w_state_nxt;
  logic [7:0]            r_hcnt;
  logic                  w_pop;
  logic                  w_discard;
  logic                  w_upd;
  logic                  w_glob;

  // Held update fields
  logic [7:0]            r_up_reg;
  logic [7:0]            r_up_din;
  logic [CW-1:0]         r_up_ch;
  logic [1:0]            r_up_op;
  logic [CW-1:0]         w_new_ch;
  logic [1:0]            w_new_op;

  assign w_wr_edge    = write && !r_write;
  assign w_push       = w_wr_edge && addr[0];
  assign w_push_entry = '{bank: r_sel_bank, regn: r_sel_reg, data: din};
  assign w_head       = wentry_t'(w_fifo_dout);
  assign w_discard    = is_discard(w_head.regn);

  assign clk_en = cen && (r_cen_cnt == r_cen_lim);
  assign busy   = !w_empty || (r_state != ST_IDLE);

  // Write edge detector and address latch; address writes bypass the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_sel_reg  <= '0;
      r_sel_bank <= '0;
    end else begin
      r_write <= write;
      if (w_wr_edge && !addr[0]) begin
        r_sel_reg  <= din;
        r_sel_bank <= BANK_W_MAX'(addr >> 1);
      end
    end
  end

  // Sticky overflow: a data write hit a full queue with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ovf <= 1'b0;
    else if (w_push && w_full && !w_pop)       ovf <= 1'b1;
  end

  jt12_mmr_wfifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_wfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_entry),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Clock divider; a newly dispatched limit only takes effect at the next wrap
  // so the period in flight is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cen_cnt <= '0;
      r_cen_lim <= 3'd5;
    end else if (cen) begin
      if (r_cen_cnt == r_cen_lim) begin
        r_cen_cnt <= '0;
        r_cen_lim <= r_cen_lim_nxt;
      end else begin
        r_cen_cnt <= r_cen_cnt + 3'd1;
      end
    end
  end

  // Dispatcher state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Dispatcher next state: discarded entries skip the hold entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pop) w_state_nxt = w_discard ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (clk_en && (r_hcnt == '0)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dispatcher outputs: pop and classify the queue head on an idle clk_en.
  always_comb begin
    w_pop  = 1'b0;
    w_upd  = 1'b0;
    w_glob = 1'b0;
    if ((r_state == ST_IDLE) && clk_en && !w_empty) begin
      w_pop  = 1'b1;
      w_glob = (w_head.regn < REG_CHOP_BASE);
      w_upd  = !w_discard &&
               ((w_head.regn == REG_KON) || (w_head.regn >= REG_CHOP_BASE));
    end
  end

  // Busy hold counter, loaded at each non-discarded dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
    end else if (w_pop && !w_discard) begin
      r_hcnt <= HOLD_INIT;
    end else if ((r_state == ST_HOLD) && clk_en && (r_hcnt != '0)) begin
      r_hcnt <= r_hcnt - 8'd1;
    end
  end

  // Global register decode; timer pulses drop at the clk_en after dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfo_en        <= 1'b0;
      lfo_freq      <= '0;
      value_A       <= '0;
      value_B       <= '0;
      load_A        <= 1'b0;
      load_B        <= 1'b0;
      clr_flag_A    <= 1'b0;
      clr_flag_B    <= 1'b0;
      enable_irq_A  <= 1'b0;
      enable_irq_B  <= 1'b0;
      csm           <= 1'b0;
      effect        <= 1'b0;
      fast_timers   <= 1'b0;
      pg_stop       <= 1'b0;
      eg_stop       <= 1'b0;
      pcm           <= '0;
      pcm_en        <= 1'b0;
      r_cen_lim_nxt <= 3'd5;
    end else begin
      if (clk_en) begin
        load_A     <= 1'b0;
        load_B     <= 1'b0;
        clr_flag_A <= 1'b0;
        clr_flag_B <= 1'b0;
      end
      if (w_glob) begin
        case (w_head.regn)
          REG_TESTYM: begin
            fast_timers <= w_head.data[2];
            pg_stop     <= w_head.data[3];
            eg_stop     <= w_head.data[5];
          end
          REG_LFO: begin
            lfo_en   <= w_head.data[3];
            lfo_freq <= w_head.data[2:0];
          end
          REG_CLKA1:   value_A[9:2] <= w_head.data;
          REG_CLKA2:   value_A[1:0] <= w_head.data[1:0];
          REG_CLKB:    value_B      <= w_head.data;
          REG_TIMER: begin
            effect       <= |w_head.data[7:6];
            csm          <= (w_head.data[7:6] == 2'b10);
            clr_flag_B   <= w_head.data[5];
            clr_flag_A   <= w_head.data[4];
            enable_irq_B <= w_head.data[3];
            enable_irq_A <= w_head.data[2];
            load_B       <= w_head.data[1];
            load_A       <= w_head.data[0];
          end
          REG_PCM:     pcm[8:1] <= w_head.data;
          REG_PCM_EN:  pcm_en   <= w_head.data[7];
          REG_DACTEST: pcm[0]   <= w_head.data[3];
          REG_CLK_N6:  r_cen_lim_nxt <= 3'd5;
          REG_CLK_N3:  r_cen_lim_nxt <= 3'd2;
          REG_CLK_N2:  r_cen_lim_nxt <= 3'd1;
          default: ;
        endcase
      end
    end
  end

  // Key-on carries its channel in the data byte; other updates in the address.
  assign w_new_ch = (w_head.regn == REG_KON) ? CW'(w_head.data[2:0])
                                             : CW'({w_head.bank, w_head.regn[1:0]});
  assign w_new_op = (w_head.regn == REG_KON) ? 2'd0 : w_head.regn[3:2];

  // Update fields are presented combinationally during the strobe and held after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_reg <= '0;
      r_up_din <= '0;
      r_up_ch  <= '0;
      r_up_op  <= '0;
    end else if (w_upd) begin
      r_up_reg <= w_head.regn;
      r_up_din <= w_head.data;
      r_up_ch  <= w_new_ch;
      r_up_op  <= w_new_op;
    end
  end

  assign up_valid = w_upd;
  assign up_reg   = w_upd ? w_head.regn : r_up_reg;
  assign up_din   = w_upd ? w_head.data : r_up_din;
  assign up_ch    = w_upd ? w_new_ch    : r_up_ch;
  assign up_op    = w_upd ? w_new_op    : r_up_op;

endmodule

// File: tb/tb_jt12_mmr_q.sv
// Directed self-checking bench for jt12_mmr_q (BANKS=2, DEPTH=4, HOLD=2).
module tb_jt12_mmr_q;

  logic       clk = 1'b0;
  logic       rst_n, cen, write;
  logic [1:0] addr;
  logic [7:0] din;
  logic       clk_en, busy, ovf, lfo_en;
  logic [2:0] lfo_freq;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, clr_flag_A, clr_flag_B;
  logic       enable_irq_A, enable_irq_B, csm, effect;
  logic       fast_timers, pg_stop, eg_stop;
  logic [8:0] pcm;
  logic       pcm_en, up_valid;
  logic [7:0] up_reg, up_din;
  logic [2:0] up_ch;
  logic [1:0] up_op;

  jt12_mmr_q #(.BANKS(2), .DEPTH(4), .HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clk_en(clk_en), .write(write),
    .addr(addr), .din(din), .busy(busy), .ovf(ovf), .lfo_en(lfo_en),
    .lfo_freq(lfo_freq), .value_A(value_A), .value_B(value_B),
    .load_A(load_A), .load_B(load_B), .clr_flag_A(clr_flag_A),
    .clr_flag_B(clr_flag_B), .enable_irq_A(enable_irq_A),
    .enable_irq_B(enable_irq_B), .csm(csm), .effect(effect),
    .fast_timers(fast_timers), .pg_stop(pg_stop), .eg_stop(eg_stop),
    .pcm(pcm), .pcm_en(pcm_en), .up_valid(up_valid), .up_reg(up_reg),
    .up_din(up_din), .up_ch(up_ch), .up_op(up_op)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event log of update strobes and pulse statistics, sampled on negedge.
  int         ev_n = 0, ce_n = 0, la_hi = 0, la_ce = 0, cfa_hi = 0, lb_hi = 0;
  logic [7:0] ev_reg [64];
  logic [7:0] ev_din [64];
  logic [2:0] ev_ch  [64];
  logic [1:0] ev_op  [64];
  logic       ev_ok  [64];
  int         ev_ce  [64];

  always @(negedge clk) begin
    if (rst_n) begin
      if (up_valid && ev_n < 64) begin
        ev_reg[ev_n] = up_reg;
        ev_din[ev_n] = up_din;
        ev_ch[ev_n]  = up_ch;
        ev_op[ev_n]  = up_op;
        ev_ok[ev_n]  = clk_en;
        ev_ce[ev_n]  = ce_n;
        ev_n++;
      end
      if (clk_en) ce_n++;
      if (load_A) la_hi++;
      if (load_A && clk_en) la_ce++;
      if (clr_flag_A) cfa_hi++;
      if (load_B) lb_hi++;
    end
  end

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wr_reg(input logic bank, input logic [7:0] r, input logic [7:0] d);
    host_wr({bank, 1'b0}, r);
    host_wr({bank, 1'b1}, d);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic count_to_idle(output int k);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      if (clk_en) k++;
      @(negedge clk);
    end
    k = 999;
  endtask

  task automatic measure_period(output int p);
    p = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (clk_en) break;
    end
    if (!clk_en) return;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (clk_en) begin p = k; return; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b0; write = 1'b0; addr = '0; din = '0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_tests++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b want 0", clk_en); end
    n_tests++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_up_valid: got %b want 0", up_valid); end
    n_tests++; if (value_A !== 10'h0) begin n_fail++; $display("FAIL reset_value_A: got %h want 000", value_A); end
    n_tests++; if (pcm !== 9'h0) begin n_fail++; $display("FAIL reset_pcm: got %h want 000", pcm); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_divider();
    int p;
    bit ok;
    cen = 1'b1;
    measure_period(p);
    n_tests++; if (p !== 6) begin n_fail++; $display("FAIL div_reset_period: got %0d want 6", p); end
    wr_reg(1'b0, 8'h2F, 8'h00);
    wait_idle(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL div_idle_2f: got timeout want idle"); end
    measure_period(p);
    n_tests++; if (p !== 2) begin n_fail++; $display("FAIL div_period_2f: got %0d want 2", p); end
    wr_reg(1'b0, 8'h2E, 8'h00);
    wait_idle(ok);
    measure_period(p);
    n_tests++; if (p !== 3) begin n_fail++; $display("FAIL div_period_2e: got %0d want 3", p); end
  endtask

  task automatic test_queueing();
    logic [7:0] er [4] = '{8'h40, 8'h45, 8'h4A, 8'h4C};
    logic [7:0] ed [4] = '{8'h7F, 8'h11, 8'h22, 8'h33};
    logic [2:0] ec [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    logic [1:0] eo [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int base;
    bit ok;
    base = ev_n;
    for (int i = 0; i < 4; i++) wr_reg(1'b0, er[i], ed[i]);
    wait_idle(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL q_idle: got timeout want idle"); end
    n_tests++; if (ev_n - base !== 4) begin n_fail++; $display("FAIL q_count: got %0d want 4", ev_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ev_reg[base+i] !== er[i]) begin n_fail++; $display("FAIL q_reg%0d: got %h want %h", i, ev_reg[base+i], er[i]); end
      n_tests++; if (ev_din[base+i] !== ed[i]) begin n_fail++; $display("FAIL q_din%0d: got %h want %h", i, ev_din[base+i], ed[i]); end
      n_tests++; if (ev_ch[base+i] !== ec[i]) begin n_fail++; $display("FAIL q_ch%0d: got %h want %h", i, ev_ch[base+i], ec[i]); end
      n_tests++; if (ev_op[base+i] !== eo[i]) begin n_fail++; $display("FAIL q_op%0d: got %h want %h", i, ev_op[base+i], eo[i]); end
      n_tests++; if (ev_ok[base+i] !== 1'b1) begin n_fail++; $display("FAIL q_cen%0d: got %b want 1", i, ev_ok[base+i]); end
      if (i > 0) begin
        n_tests++;
        if (ev_ce[base+i] - ev_ce[base+i-1] !== 3) begin
          n_fail++; $display("FAIL q_spacing%0d: got %0d want 3", i, ev_ce[base+i] - ev_ce[base+i-1]);
        end
      end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL q_busy: got %b want 0", busy); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL q_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_channel_map();
    int base, k;
    bit ok;
    base = ev_n;
    wr_reg(1'b1, 8'h5E, 8'h1F);
    wait_idle(ok);
    n_tests++; if (ev_n - base !== 1) begin n_fail++; $display("FAIL cm_count: got %0d want 1", ev_n - base); end
    n_tests++; if (ev_ch[base] !== 3'b110) begin n_fail++; $display("FAIL cm_ch: got %b want 110", ev_ch[base]); end
    n_tests++; if (up_op !== 2'd3) begin n_fail++; $display("FAIL cm_op_held: got %0d want 3", up_op); end
    n_tests++; if (up_din !== 8'h1F) begin n_fail++; $display("FAIL cm_din_held: got %h want 1f", up_din); end
    n_tests++; if (up_reg !== 8'h5E) begin n_fail++; $display("FAIL cm_reg_held: got %h want 5e", up_reg); end
    // slot 3 is discarded without a hold
    base = ev_n;
    wr_reg(1'b0, 8'h33, 8'hAA);
    count_to_idle(k);
    n_tests++; if (k !== 1) begin n_fail++; $display("FAIL cm_discard_hold: got %0d want 1", k); end
    @(negedge clk);
    n_tests++; if (ev_n - base !== 0) begin n_fail++; $display("FAIL cm_discard_strobe: got %0d want 0", ev_n - base); end
    // key-on takes its channel from data
    base = ev_n;
    wr_reg(1'b0, 8'h28, 8'hF6);
    count_to_idle(k);
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL kon_hold: got %0d want 3", k); end
    @(negedge clk);
    n_tests++; if (ev_n - base !== 1) begin n_fail++; $display("FAIL kon_count: got %0d want 1", ev_n - base); end
    n_tests++; if (ev_ch[base] !== 3'b110 || ev_op[base] !== 2'd0 || ev_din[base] !== 8'hF6)
      begin n_fail++; $display("FAIL kon_fields: got ch=%b op=%0d din=%h want ch=110 op=0 din=f6", ev_ch[base], ev_op[base], ev_din[base]); end
    // A0h range passes through
    base = ev_n;
    wr_reg(1'b1, 8'hA6, 8'h44);
    wait_idle(ok);
    n_tests++; if (ev_ch[base] !== 3'b110 || ev_op[base] !== 2'd1 || ev_reg[base] !== 8'hA6)
      begin n_fail++; $display("FAIL a6_fields: got ch=%b op=%0d reg=%h want ch=110 op=1 reg=a6", ev_ch[base], ev_op[base], ev_reg[base]); end
  endtask

  task automatic test_globals();
    int base;
    bit ok;
    base = ev_n;
    wr_reg(1'b0, 8'h21, 8'h2C); wait_idle(ok);
    wr_reg(1'b0, 8'h22, 8'h0B); wait_idle(ok);
    wr_reg(1'b0, 8'h2A, 8'hA5); wait_idle(ok);
    wr_reg(1'b0, 8'h2C, 8'h08); wait_idle(ok);
    wr_reg(1'b0, 8'h2B, 8'h80); wait_idle(ok);
    wr_reg(1'b0, 8'h20, 8'hFF); wait_idle(ok);
    n_tests++; if ({fast_timers, pg_stop, eg_stop} !== 3'b111) begin n_fail++; $display("FAIL g_21: got %b want 111", {fast_timers, pg_stop, eg_stop}); end
    n_tests++; if ({lfo_en, lfo_freq} !== 4'hB) begin n_fail++; $display("FAIL g_lfo: got %h want b", {lfo_en, lfo_freq}); end
    n_tests++; if (pcm !== 9'h14B) begin n_fail++; $display("FAIL g_pcm: got %h want 14b", pcm); end
    n_tests++; if (pcm_en !== 1'b1) begin n_fail++; $display("FAIL g_pcm_en: got %b want 1", pcm_en); end
    n_tests++; if (ev_n - base !== 0) begin n_fail++; $display("FAIL g_no_strobe: got %0d want 0", ev_n - base); end
  endtask

  task automatic test_timer();
    int la0, lc0, cf0, lb0;
    bit ok;
    la0 = la_hi; lc0 = la_ce; cf0 = cfa_hi; lb0 = lb_hi;
    wr_reg(1'b0, 8'h24, 8'hFF);
    wr_reg(1'b0, 8'h25, 8'h03);
    wr_reg(1'b0, 8'h26, 8'h5A);
    wr_reg(1'b0, 8'h27, 8'h15);
    wait_idle(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t_idle: got timeout want idle"); end
    n_tests++; if (value_A !== 10'h3FF) begin n_fail++; $display("FAIL t_value_A: got %h want 3ff", value_A); end
    n_tests++; if (value_B !== 8'h5A) begin n_fail++; $display("FAIL t_value_B: got %h want 5a", value_B); end
    n_tests++; if ({enable_irq_B, enable_irq_A} !== 2'b01) begin n_fail++; $display("FAIL t_irq_en: got %b want 01", {enable_irq_B, enable_irq_A}); end
    n_tests++; if (la_hi - la0 !== 3) begin n_fail++; $display("FAIL t_load_A_width: got %0d want 3", la_hi - la0); end
    n_tests++; if (la_ce - lc0 !== 1) begin n_fail++; $display("FAIL t_load_A_cen: got %0d want 1", la_ce - lc0); end
    n_tests++; if (cfa_hi - cf0 !== 3) begin n_fail++; $display("FAIL t_clr_A_width: got %0d want 3", cfa_hi - cf0); end
    n_tests++; if (lb_hi - lb0 !== 0) begin n_fail++; $display("FAIL t_load_B: got %0d want 0", lb_hi - lb0); end
    n_tests++; if ({csm, effect} !== 2'b00) begin n_fail++; $display("FAIL t_csm_eff0: got %b want 00", {csm, effect}); end
    wr_reg(1'b0, 8'h27, 8'hC0);
    wait_idle(ok);
    n_tests++; if ({csm, effect, enable_irq_A} !== 3'b010) begin n_fail++; $display("FAIL t_csm_eff1: got %b want 010", {csm, effect, enable_irq_A}); end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    base = ev_n;
    @(negedge clk); cen = 1'b0;
    host_wr(2'b00, 8'h50);
    for (int i = 1; i <= 5; i++) host_wr(2'b01, 8'(i));
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b want 1", busy); end
    cen = 1'b1;
    wait_idle(ok);
    n_tests++; if (ev_n - base !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", ev_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (ev_din[base+i] !== 8'(i + 1) || ev_reg[base+i] !== 8'h50) begin
        n_fail++; $display("FAIL ovf_entry%0d: got reg=%h din=%h want reg=50 din=%h", i, ev_reg[base+i], ev_din[base+i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_reset_hold();
    int base, p;
    base = ev_n;
    host_wr(2'b00, 8'h40);
    host_wr(2'b01, 8'h01);
    host_wr(2'b01, 8'h02);
    host_wr(2'b01, 8'h03);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rh_busy_before: got %b want 1", busy); end
    n_tests++; if (ev_n - base !== 1) begin n_fail++; $display("FAIL rh_one_dispatched: got %0d want 1", ev_n - base); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rh_busy: got %b want 0", busy); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rh_ovf: got %b want 0", ovf); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = ev_n;
    repeat (40) @(negedge clk);
    n_tests++; if (ev_n - base !== 0) begin n_fail++; $display("FAIL rh_stale: got %0d want 0", ev_n - base); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rh_busy_after: got %b want 0", busy); end
    measure_period(p);
    n_tests++; if (p !== 6) begin n_fail++; $display("FAIL rh_period: got %0d want 6", p); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_queueing();
    test_channel_map();
    test_globals();
    test_timer();
    test_overflow();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jt12_mmr_q.md
Name: jt12_mmr_q

Overview:
Parametrised host-write front end for the JT12 family. It takes CPU address/data writes across a configurable number of register banks and queues data writes in a FIFO. Queued writes are dispatched to the register file at the clk_en rate with a programmable busy hold, so the host never has to poll busy between writes. Global registers (timers, LFO, PCM, test, clock divider) are decoded here. Channel and operator writes leave as a single update strobe that carries reg, channel, operator and data.

Parameters:
BANKS, 2, number of register banks (1 = 3-channel part, 2 = 6-channel part); channel field width CW = 2 + clog2(BANKS), minimum 2
DEPTH, 4, data-write FIFO depth (power of 2, 2..16)
HOLD, 32, clk_en ticks for which busy is held after each dispatched write (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  master clock enable
clk_en  out  1  divided enable: cen & (cen_cnt==cen_lim)
write  in  1  host write; acts on its rising edge
addr  in  1+clog2(BANKS)  bit0: 0=address, 1=data; upper bits: bank
din  in  8  host data
busy  out  1  FIFO non-empty or dispatcher not IDLE
ovf  out  1  sticky: a data write was dropped
lfo_en, lfo_freq  out  1,3  reg 22h
value_A, value_B  out  10,8  regs 24h/25h, 26h
load_A, load_B, clr_flag_A, clr_flag_B  out  1 each  one-clk_en-period pulses, reg 27h
enable_irq_A, enable_irq_B, csm, effect  out  1 each  reg 27h
fast_timers, pg_stop, eg_stop  out  1 each  reg 21h bits 2,3,5
pcm, pcm_en  out  9,1  2Ah -> pcm[8:1], 2Ch bit3 -> pcm[0], 2Bh bit7 -> pcm_en
up_valid  out  1  one-clk pulse, coincident with clk_en; channel/operator update
up_reg, up_din  out  8,8  register number and data
up_ch  out  CW  {bank, reg[1:0]}
up_op  out  2  reg[3:2] (0=S1,1=S3,2=S2,3=S4)

Behaviour:
- Reset: all outputs 0 except cen_lim=5; FIFO empty; FSM IDLE; selected register and bank cleared; ovf 0.
- Edge detect: write_r <= write; action on write & ~write_r only.
- Address write: latches sel_reg=din and sel_bank=addr[MSB:1] immediately. It is not queued and does not affect busy.
- Data write: pushes {sel_bank, sel_reg, din}.
  - FIFO full with no pop in the same clk: write dropped, ovf<=1.
  - Full with a simultaneous pop: push accepted.
- Divider: cen_cnt advances on cen and wraps at cen_lim. A dispatched 2Dh/2Eh/2Fh sets cen_lim to 5/2/1. The new value applies from the next wrap; cen_cnt is never forced.
- FSM states and transitions:
  - IDLE: on clk_en with FIFO non-empty -> pop, decode and go to HOLD with hcnt=HOLD-1.
  - HOLD: hcnt decrements on each clk_en; at 0 on a clk_en -> IDLE.
  - A write popped in the same clk_en as HOLD ends waits for the next clk_en; no back-to-back dispatch.
- Decode at pop:
  - reg<30h: update the global outputs listed under Ports; unknown global registers are ignored but still HOLD.
  - reg 28h: up_valid with up_ch taken from din[2:0] per chip convention; up_op=0.
  - reg>=30h and reg[1:0]!=3: up_valid=1 for that clk.
  - reg>=30h and reg[1:0]==3: discarded and returns straight to IDLE (no HOLD).
  - A0h–AEh: passed through unchanged. Ch3 special-mode latching is the register file's job.
- Pulses: load_A/B and clr_flag_A/B are set at dispatch and cleared at the next clk_en.
- up_reg/up_ch/up_op/up_din hold their values until the next dispatch.
- rst_n asserted mid-HOLD or with the FIFO non-empty: everything is cleared immediately and queued writes are lost.

Decomposition:
- Package jt12_mmr_pkg holds:
  - register address constants (REG_TESTYM, REG_LFO, REG_CLKA1, REG_CLKA2, REG_CLKB, REG_TIMER, REG_KON, REG_PCM, REG_PCM_EN, REG_DACTEST, REG_CLK_N6/N3/N2);
  - the FSM state enum;
  - the FIFO entry struct {bank, reg, data}.
- One sub-module, jt12_mmr_wfifo: synchronous FIFO parametrised by DEPTH and width, with full/empty flags and same-cycle push/pop.

Test Plan:
- Divider: reset, cen=1 constantly -> clk_en every 6 clk. Dispatch 2Fh -> after next wrap, clk_en every 2 clk. Then 2Eh -> clk_en every 3 clk.
- Queueing: DEPTH=4, HOLD=2, 4 back-to-back pairs (addr 40h/data 7Fh etc.) without polling -> 4 up_valid pulses spaced 3 clk_en apart; busy falls after the last HOLD; ovf=0.
- Overflow: fill FIFO during HOLD with 5 data writes -> 5th dropped, ovf=1, only 4 up_valid.
- Channel mapping: BANKS=2, addr=2 (bank 1), reg 5Eh, data 1Fh -> up_ch=3'b110, up_op=3, up_din=1Fh. Reg 33h -> no up_valid, no HOLD.
- Timer pulses: 24h=FFh, 25h=03h, 27h=15h -> value_A=3FFh, enable_irq_A=1, load_A and clr_flag_A high for exactly one clk_en period.
- Reset mid-HOLD with 2 queued entries: rst_n low -> busy=0 and FIFO empty immediately. After release, no stale up_valid and cen_lim=5.
